// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the data-memory stage: icode constants, the
// access FSM state type and small icode-decode helpers.
package y86_pkg;

    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;
    localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [3:0] ICODE_POPQ   = 4'hB;

    // Wide enough for the largest legal LATENCY (15).
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } dmem_state_e;

    function automatic logic is_read(input logic [3:0] icode);
        return (icode == ICODE_MRMOVQ) || (icode == ICODE_RET) || (icode == ICODE_POPQ);
    endfunction

    function automatic logic is_write(input logic [3:0] icode);
        return (icode == ICODE_RMMOVQ) || (icode == ICODE_CALL) || (icode == ICODE_PUSHQ);
    endfunction

    // ret and popq address through the stack pointer carried on valA.
    function automatic logic addr_from_vala(input logic [3:0] icode);
        return (icode == ICODE_RET) || (icode == ICODE_POPQ);
    endfunction

    // call stores the return address (valP); other writes store valA.
    function automatic logic data_from_valp(input logic [3:0] icode);
        return (icode == ICODE_CALL);
    endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Word storage for the Y86-64 data memory: synchronous write, combinational read.
// Contents start at zero and are never cleared by reset.
module y86_dmem_array #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Indices past DEPTH only occur for faulting accesses, whose data is discarded.
    assign rdata_o = (32'(raddr_i) < DEPTH) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/y86_data_memory.sv
// Multi-cycle Y86-64 data memory with icode decode, latency FSM and fault reporting.
// Define Y86_DMEM_ALIGN_CHECK_EN to make misaligned addresses fault.
module y86_data_memory
    import y86_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [3:0]        icode,
    input  logic [63:0]       valE,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valP,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] valM,
    output logic              dmem_error
);

    localparam int               AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [63:0]      MEM_BYTES = 64'(DEPTH) << 3;
    localparam logic [CNT_W-1:0] LAT_CNT   = CNT_W'(LATENCY);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] valm_q, valm_d;
    logic [3:0]        icode_q, icode_d;
    logic [63:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              rd_op, wr_op;
    logic              range_fault, align_fault, access_fault;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata, rd_word;
    logic [CNT_W-1:0]  cnt_dec;

    assign rd_op       = is_read(icode_q);
    assign wr_op       = is_write(icode_q);
    assign range_fault = (addr_q >= MEM_BYTES);
`ifdef Y86_DMEM_ALIGN_CHECK_EN
    assign align_fault = |addr_q[2:0];
`else
    assign align_fault = 1'b0;
`endif
    // NOP icodes touch nothing, so they can never fault.
    assign access_fault = (rd_op || wr_op) && (range_fault || align_fault);

    // A reset landing on the DONE cycle must abort the commit.
    assign mem_we  = (state_q == ST_DONE) && wr_op && !access_fault && !rst;
    assign rd_word = (rd_op && !access_fault) ? mem_rdata : '0;

    y86_dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_array (
        .clk_i   (clk),
        .we_i    (mem_we),
        .waddr_i (addr_q[AW+2:3]),
        .wdata_i (wdata_q),
        .raddr_i (addr_q[AW+2:3]),
        .rdata_o (mem_rdata)
    );

    assign cnt_dec = cnt_q - CNT_W'(1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valm_d  = valm_q;
        icode_d = icode_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    icode_d = icode;
                    addr_d  = addr_from_vala(icode) ? valA : valE;
                    wdata_d = data_from_valp(icode) ? valP : valA;
                    cnt_d   = LAT_CNT;
                    state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_dec;
                if (cnt_dec <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                valm_d  = rd_word;
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            valm_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valm_q  <= valm_d;
        end
    end

    // Request payload carries no reset; it is only consumed behind a live state.
    always_ff @(posedge clk) begin
        icode_q <= icode_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
    end

    assign ready      = (state_q == ST_IDLE);
    assign done       = (state_q == ST_DONE) && !rst;
    assign dmem_error = done && access_fault;
    assign valM       = (state_q == ST_DONE) ? rd_word : valm_q;

endmodule
